// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue controller: drives the fetch PC, resolves JMP in fetch and
// inserts RAW-hazard bubbles when built with `define HAZARD_INTERLOCK_EN.
module fetch_sequencer #(
  parameter int         HAZARD_DEPTH = 3,
  parameter logic [6:0] OP_NOP       = 7'd0,
  parameter logic [6:0] OP_JMP       = 7'd1,
  parameter logic [6:0] OP_ST        = 7'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        stall_i,
  output logic [13:0] pc_o,
  input  logic [31:0] ir_i,
  output logic [31:0] ir_o,
  output logic        ir_valid_o,
  output logic        bubble_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [31:0] NOP_WORD = {OP_NOP, 25'd0};

  state_t     state;
  logic [6:0] opcode;
  logic       is_jmp;
  logic       hazard;

  assign opcode = ir_i[31:25];
  assign is_jmp = (opcode == OP_JMP);

  if ((HAZARD_DEPTH < 1) || (HAZARD_DEPTH > 7) || (OP_ST == OP_NOP) ||
      (OP_ST == OP_JMP) || (OP_NOP == OP_JMP)) begin : g_bad_cfg
    $error("fetch_sequencer: illegal HAZARD_DEPTH or overlapping opcodes");
  end

`ifdef HAZARD_INTERLOCK_EN
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       has_src;
  logic       is_st;
  logic [4:0] dest;
  logic       issue;
  logic [4:0] sb [HAZARD_DEPTH];

  assign rd      = ir_i[24:20];
  assign rs1     = ir_i[19:15];
  assign rs2     = ir_i[14:10];
  assign has_src = (opcode != OP_NOP) && !is_jmp;
  assign is_st   = (opcode == OP_ST);
  assign dest    = (has_src && !is_st) ? rd : 5'd0;
  assign issue   = (state == RUN) && en && !hazard && !is_jmp;

  // Any live source hitting a recent nonzero destination stalls issue; ST reads its rd.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZARD_DEPTH; i++) begin
      hazard = hazard | ((sb[i] != 5'd0) &&
                         ((has_src && ((rs1 == sb[i]) || (rs2 == sb[i]))) ||
                          (is_st && (rd == sb[i]))));
    end
  end

  // Destination history of the last HAZARD_DEPTH issue slots; non-issue slots push R0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < HAZARD_DEPTH; i++) begin
        sb[i] <= 5'd0;
      end
    end else if (!stall_i) begin
      sb[0] <= issue ? dest : 5'd0;
      for (int i = 1; i < HAZARD_DEPTH; i++) begin
        sb[i] <= sb[i-1];
      end
    end
  end
`else
  assign hazard = 1'b0;
`endif

  // Fetch/issue state machine; stall freezes every register including the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc_o       <= 14'd0;
      ir_o       <= NOP_WORD;
      ir_valid_o <= 1'b0;
      bubble_o   <= 1'b0;
    end else if (!stall_i) begin
      case (state)
        IDLE: begin
          ir_o       <= NOP_WORD;
          ir_valid_o <= 1'b0;
          bubble_o   <= 1'b0;
          if (en) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!en) begin
            state      <= IDLE;
            ir_o       <= NOP_WORD;
            ir_valid_o <= 1'b0;
            bubble_o   <= 1'b0;
          end else if (hazard) begin
            ir_o       <= NOP_WORD;
            ir_valid_o <= 1'b0;
            bubble_o   <= 1'b1;
          end else if (is_jmp) begin
            // Low 14 bits of the sign-extended offset give the modulo-2^14 target.
            pc_o       <= pc_o + ir_i[13:0];
            ir_o       <= NOP_WORD;
            ir_valid_o <= 1'b0;
            bubble_o   <= 1'b0;
          end else begin
            pc_o       <= pc_o + 14'd1;
            ir_o       <= ir_i;
            ir_valid_o <= 1'b1;
            bubble_o   <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          ir_o       <= NOP_WORD;
          ir_valid_o <= 1'b0;
          bubble_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: vector table, directed corner sequences and a randomized
// run, all checked against a rule-level reference model of fetch/issue.
module tb_fetch_sequencer;

  localparam int HD = 3;
  localparam logic [6:0] OP_NOP = 7'd0;
  localparam logic [6:0] OP_JMP = 7'd1;
  localparam logic [6:0] OP_ST  = 7'd2;
  localparam logic [6:0] OP_ADD = 7'd3;
  localparam logic [6:0] OP_ADI = 7'd4;
  localparam logic [31:0] NOPW  = 32'd0;
`ifdef HAZARD_INTERLOCK_EN
  localparam bit INTERLOCK = 1'b1;
`else
  localparam bit INTERLOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        stall_i = 1'b0;
  logic [13:0] pc_o;
  logic [31:0] ir_i;
  logic [31:0] ir_o;
  logic        ir_valid_o;
  logic        bubble_o;

  logic [31:0] mem [16384];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  assign ir_i = mem[pc_o];

  fetch_sequencer #(.HAZARD_DEPTH(HD), .OP_NOP(OP_NOP), .OP_JMP(OP_JMP), .OP_ST(OP_ST)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .stall_i(stall_i), .pc_o(pc_o),
    .ir_i(ir_i), .ir_o(ir_o), .ir_valid_o(ir_valid_o), .bubble_o(bubble_o)
  );

  function automatic logic [31:0] r_op(logic [6:0] op, int rd, int rs1, int rs2);
    return {op, 5'(rd), 5'(rs1), 5'(rs2), 10'd0};
  endfunction

  function automatic logic [31:0] i_op(logic [6:0] op, int rd, int rs1, int imm);
    return {op, 5'(rd), 5'(rs1), 15'(imm)};
  endfunction

  // ---------------- reference model ----------------
  int          m_pc;
  bit          m_run;
  logic [31:0] m_ir;
  bit          m_v;
  bit          m_b;
  logic [4:0]  m_hist[$];   // destinations of recent issue slots, newest first

  function automatic bit model_hazard(logic [31:0] w);
    logic [6:0] op;
    logic [4:0] srcs[$];
    op = w[31:25];
    if (!INTERLOCK) return 1'b0;
    if (op != OP_NOP && op != OP_JMP) begin
      srcs.push_back(w[19:15]);
      srcs.push_back(w[14:10]);
    end
    if (op == OP_ST) srcs.push_back(w[24:20]);
    foreach (srcs[i])
      if (srcs[i] != 5'd0)
        foreach (m_hist[j])
          if (m_hist[j] == srcs[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge(bit rst, bit e, bit st);
    logic [31:0] w;
    logic [6:0]  op;
    logic [4:0]  d;
    int          off;
    if (rst) begin
      m_pc = 0; m_run = 1'b0; m_ir = NOPW; m_v = 1'b0; m_b = 1'b0;
      m_hist.delete();
      repeat (HD) m_hist.push_back(5'd0);
    end else if (!st) begin
      w = mem[m_pc];
      op = w[31:25];
      d = 5'd0;
      if (!m_run) begin
        m_ir = NOPW; m_v = 1'b0; m_b = 1'b0; m_run = e;
      end else if (!e) begin
        m_run = 1'b0; m_ir = NOPW; m_v = 1'b0; m_b = 1'b0;
      end else if (model_hazard(w)) begin
        m_ir = NOPW; m_v = 1'b0; m_b = 1'b1;
      end else if (op == OP_JMP) begin
        off = w[14] ? int'(w[14:0]) - 32768 : int'(w[14:0]);
        m_pc = (m_pc + off + 32768) % 16384;
        m_ir = NOPW; m_v = 1'b0; m_b = 1'b0;
      end else begin
        m_ir = w; m_v = 1'b1; m_b = 1'b0;
        m_pc = (m_pc + 1) % 16384;
        if (op != OP_NOP && op != OP_ST) d = w[24:20];
      end
      m_hist.push_front(d);
      m_hist.delete(HD);
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(string name, logic [13:0] pc, logic [31:0] ir, logic v, logic b);
    n_cmp++;
    if (pc_o !== pc || ir_o !== ir || ir_valid_o !== v || bubble_o !== b) begin
      n_bad++;
      $display("FAIL %s t=%0t: got pc=%0d ir=%h v=%b b=%b, required pc=%0d ir=%h v=%b b=%b",
               name, $time, pc_o, ir_o, ir_valid_o, bubble_o, pc, ir, v, b);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0d, required %0d", name, $time, act, exp);
    end
  endtask

  // One clock edge with the given inputs, then compare against the model.
  task automatic tick(bit rst, bit e, bit st);
    rst_n = ~rst; en = e; stall_i = st;
    @(posedge clk);
    #1;
    model_edge(rst, e, st);
    check("model", 14'(m_pc), m_ir, m_v, m_b);
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = NOPW;
  endtask

  typedef struct {
    bit          rst;
    bit          e;
    bit          st;
    logic [13:0] pc;
    logic [31:0] ir;
    bit          v;
    bit          b;
  } vec_t;
  vec_t vt[$];

  task automatic add_vec(bit r, bit e, bit s, int pc, logic [31:0] ir, bit v, bit b);
    vec_t x;
    x.rst = r; x.e = e; x.st = s; x.pc = 14'(pc); x.ir = ir; x.v = v; x.b = b;
    vt.push_back(x);
  endtask

  function automatic logic [31:0] rand_word();
    int k;
    int imm;
    logic [6:0] op;
    k = int'($urandom_range(0, 9));
    case (k)
      0: op = OP_NOP;
      1: op = OP_JMP;
      2: op = OP_ST;
      3, 4, 5: op = OP_ADD;
      default: op = OP_ADI;
    endcase
    if (op == OP_JMP) begin
      imm = int'($urandom_range(0, 16)) - 8;
      if (imm == 0) imm = 1;
      return i_op(OP_JMP, 0, 0, imm);
    end
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 10'($urandom)};
  endfunction

  logic [31:0] a0, a1, a2, w21, wadi;
  int nb;
  bit got_valid;

  initial begin
    a0 = i_op(OP_ADI, 5, 5, 10);
    a1 = i_op(OP_ADI, 6, 6, 15);
    a2 = r_op(OP_ADD, 7, 5, 6);

    // ---- table: ADI, ADI, ADD with RAW on R6 at distance 1 ----
    clear_mem();
    mem[0] = a0; mem[1] = a1; mem[2] = a2; mem[3] = NOPW;
    add_vec(1'b1, 1'b0, 1'b0, 0, NOPW, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 0, NOPW, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1, a0,   1'b1, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 2, a1,   1'b1, 1'b0);
    if (INTERLOCK) begin
      repeat (HD) add_vec(1'b0, 1'b1, 1'b0, 2, NOPW, 1'b0, 1'b1);
    end
    add_vec(1'b0, 1'b1, 1'b0, 3, a2,   1'b1, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 4, NOPW, 1'b1, 1'b0);
    foreach (vt[i]) begin
      tick(vt[i].rst, vt[i].e, vt[i].st);
      check("vec", vt[i].pc, vt[i].ir, vt[i].v, vt[i].b);
    end

    // ---- independent stream: full throughput ----
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = i_op(OP_ADI, i + 1, i + 9, 0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("indep_start", 14'd0, NOPW, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      check("indep", 14'(i + 1), mem[i], 1'b1, 1'b0);
    end

    // ---- JMP backwards: 28 -> 21 ----
    clear_mem();
    w21 = i_op(OP_ADI, 3, 4, 0);
    mem[0]  = i_op(OP_JMP, 0, 0, 28);
    mem[28] = i_op(OP_JMP, 0, 0, -7);
    mem[21] = w21;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("jmp_fwd", 14'd28, NOPW, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("jmp_back", 14'd21, NOPW, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("jmp_target", 14'd22, w21, 1'b1, 1'b0);

    // ---- PC wrap 16383 -> 0 ----
    clear_mem();
    wadi = i_op(OP_ADI, 1, 2, 0);
    mem[0] = i_op(OP_JMP, 0, 0, 16383);
    mem[16383] = wadi;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("wrap_top", 14'd16383, NOPW, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("wrap_zero", 14'd0, wadi, 1'b1, 1'b0);

    // ---- stall for 4 cycles after the first bubble ----
    clear_mem();
    mem[0] = a0; mem[1] = a1; mem[2] = a2; mem[3] = NOPW;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      check("stall_hold", INTERLOCK ? 14'd2 : 14'd3, INTERLOCK ? NOPW : a2,
            INTERLOCK ? 1'b0 : 1'b1, INTERLOCK ? 1'b1 : 1'b0);
    end
    nb = 0;
    got_valid = 1'b0;
    for (int k = 0; k < 10 && !got_valid; k++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (ir_valid_o) got_valid = 1'b1;
      else if (bubble_o) nb++;
    end
    check_int("stall_valid_seen", int'(got_valid), 1);
    check_int("stall_bubbles_left", nb, INTERLOCK ? HD - 1 : 0);
    check("stall_release_issue", INTERLOCK ? 14'd3 : 14'd4, INTERLOCK ? a2 : NOPW, 1'b1, 1'b0);

    // ---- reset mid-bubble at pc 9 (reset wins over stall) ----
    clear_mem();
    mem[0] = a2; mem[8] = a0; mem[9] = a2;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0);
    check("pre_rst", INTERLOCK ? 14'd9 : 14'd10, INTERLOCK ? NOPW : a2,
          INTERLOCK ? 1'b0 : 1'b1, INTERLOCK ? 1'b1 : 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    check("rst_mid", 14'd0, NOPW, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("rst_idle", 14'd0, NOPW, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("rst_sb_clear", 14'd1, a2, 1'b1, 1'b0);

    // ---- randomized run against the model ----
    foreach (mem[i]) mem[i] = rand_word();
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 90, $urandom_range(0, 99) < 20);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and issue controller for the RISC core. Drives the 14-bit word address into the instruction memory, registers the returned 32-bit instruction and issues it to decode. Resolves JMP in the fetch stage and inserts NOP bubbles on read-after-write hazards against the last HAZARD_DEPTH issued instructions, so programs no longer need hand-placed NOPs.

## Interface
Parameters:
- HAZARD_DEPTH, 3: issued-instruction window checked for RAW hazards (1..7).
- OP_NOP, 7'd0: NOP opcode.
- OP_JMP, 7'd1: JMP opcode.
- OP_ST, 7'd2: ST opcode. Its rd field is a source, not a destination.

Ports:
- clk  in  1  rising-edge clock; the single clock.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  run enable; low holds the PC.
- stall_i  in  1  downstream back-pressure; high freezes the block.
- pc_o  out  14  registered instruction-memory word address.
- ir_i  in  32  instruction word from memory; combinational in pc_o.
- ir_o  out  32  issued instruction; a bubble is the NOP word {OP_NOP, 25'd0}.
- ir_valid_o  out  1  high when ir_o holds a real (non-bubble) instruction.
- bubble_o  out  1  high when ir_o is an inserted hazard bubble.

## Operation
Instruction field layout:
- [31:25] opcode.
- [24:20] rd.
- [19:15] rs1.
- [14:10] rs2.
- [14:0] imm15.

Decode of ir_i:
- Sources: rs1 and rs2 for every opcode except NOP and JMP; ST adds rd as a source. Conservative by design.
- Destination: rd for every opcode except NOP, JMP and ST.
- R0 is never a hazard. Source or destination index 0 never matches.

Scoreboard:
- HAZARD_DEPTH-entry shift register of 5-bit destination indices.
- On every non-stalled edge, shifts in the destination of the instruction issued this edge, or 0 for a bubble, NOP or JMP.

States:
- IDLE: entered from reset.
  - en=1: go to RUN.
  - Otherwise: pc_o holds, ir_o=NOP, ir_valid_o=0, scoreboard shifts 0.
- RUN: each non-stalled edge, exactly one of the following, in priority order:
  1. en=0: go to IDLE. pc_o holds. Issue a non-valid NOP (bubble_o=0).
  2. Hazard (a source of ir_i matches any scoreboard entry): pc_o holds. Issue a bubble (ir_o=NOP, ir_valid_o=0, bubble_o=1).
  3. ir_i opcode is OP_JMP: pc_o <= pc_o + sext(imm15)[13:0], modulo 2^14. Issue a NOP, ir_valid_o=0, bubble_o=0. JMP is consumed and never reaches decode.
  4. Otherwise: ir_o <= ir_i, ir_valid_o=1, bubble_o=0, pc_o <= pc_o + 1. The PC wraps 16383 -> 0.

Stall:
- stall_i=1 overrides everything: pc_o, ir_o, ir_valid_o, bubble_o, the state and the scoreboard all hold.
- Reset has priority over stall_i.

Reset (rst_n=0 at an edge):
- pc_o=0, ir_o=NOP word, ir_valid_o=0, bubble_o=0, scoreboard all 0, state IDLE.
- Reset mid-run discards any in-progress bubble sequence. The first fetch after release is address 0.

## Timing
- Memory read is combinational: ir_i is valid for the current pc_o within the same cycle.
- Latency: the instruction at pc_o appears on ir_o one edge later.
- Throughput: one instruction per cycle with no hazards, stalls or jumps.
- A taken JMP costs one non-valid slot. The target instruction issues on the second edge after the JMP was presented.
- A dependent instruction issued immediately after its producer sees HAZARD_DEPTH bubbles. At distance k (k ≤ HAZARD_DEPTH) it sees HAZARD_DEPTH-k+1 bubbles. At distance > HAZARD_DEPTH it sees none.
- A JMP whose target contains a hazard is handled normally on the following cycle; no combined action occurs.
- en is sampled at edges. Deasserting it issues a NOP that same edge, and the fetched instruction is not consumed.

## Configuration
- HAZARD_INTERLOCK_EN defined: scoreboard and bubble insertion as described.
- HAZARD_INTERLOCK_EN undefined:
  - No scoreboard is built and the hazard term is constant 0.
  - bubble_o is tied 0.
  - Software must pad dependencies with HAZARD_DEPTH NOPs.
  - JMP, stall and reset behaviour are unchanged.

## Test plan
- Reset, then en=1, with memory words 0..3 = ADI R5,R5,10; ADI R6,R6,15; ADD R7,R5,R6; NOP:
  - Interlock on: ir_o = ADI, ADI, bubble, bubble, bubble, ADD.
  - Interlock off: ir_o = ADI, ADI, ADD with no bubbles.
- Independent stream at words 0..7 (no shared registers): 8 consecutive ir_valid_o=1 cycles, pc_o = 0..8, bubble_o never high.
- JMP at word 28 with imm15 = 15'o77771 (-7):
  - pc_o goes 28 -> 21.
  - One cycle with ir_valid_o=0 and bubble_o=0.
  - Next valid ir_o is word 21.
- Wrap: pc_o=16383 holding an independent ADI; next pc_o=0 and ir_valid_o=1 for the ADI.
- stall_i=1 for 4 cycles in the middle of a bubble sequence: all outputs frozen. After release, the remaining bubble count is unchanged and the ADD issues.
- rst_n=0 for one edge while ir_o=bubble and pc_o=9: next outputs are pc_o=0, ir_o=NOP, ir_valid_o=0, bubble_o=0, with the scoreboard cleared.
